// File: rtl/riscv.sv
// Shared RISC-V definitions used by the CSR counter bank: widths, CSR address type and op encoding.
package riscv;

    localparam int unsigned XLEN = 64;

    typedef logic [11:0] csr_reg_t;

    typedef enum logic [1:0] {
        CSR_OP_NONE,
        CSR_OP_RW,
        CSR_OP_RS,
        CSR_OP_RC
    } csr_op_t;

    localparam int unsigned HPM_NUM_EVT        = 14;
    localparam int unsigned HPM_RESERVED_FIRST = 17;

    localparam logic [1:0] PRIV_M = 2'b11;

    // Upper seven address bits selecting the 32-entry Bxx and Cxx windows.
    localparam logic [6:0] CSR_MCNT_PAGE = 7'h58;
    localparam logic [6:0] CSR_UCNT_PAGE = 7'h60;

endpackage

// File: rtl/hpm_counter.sv
// Single free-running counter; a write in the same cycle replaces the increment.
module hpm_counter #(
    parameter int unsigned Width = 64
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             wr_en_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             inc_i,
    output logic [Width-1:0] value_o
);

    logic [Width-1:0] value_q, value_d;

    always_comb begin
        value_d = value_q + {{(Width-1){1'b0}}, inc_i};
        if (wr_en_i) begin
            value_d = wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/csr_hpm_counters.sv
// CSR responder for the mcycle/minstret/mhpmcounter bank and its user read-only shadows.
module csr_hpm_counters
    import riscv::*;
#(
    parameter int unsigned XLEN    = riscv::XLEN,
    parameter int unsigned NUM_EVT = riscv::HPM_NUM_EVT
) (
    input  logic               clk_i,
    input  logic               reset_ni,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  csr_reg_t           req_addr_i,
    input  csr_op_t            req_op_i,
    input  logic               req_wr_i,
    input  logic [XLEN-1:0]    req_wdata_i,
    input  logic [1:0]         req_priv_i,
    input  logic [31:0]        mcounteren_i,
    input  logic               instret_inc_i,
    input  logic [NUM_EVT-1:0] evt_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [XLEN-1:0]    rsp_rdata_o,
    output logic               rsp_illegal_o
);

    logic [4:0]      idx;
    logic            in_m, in_u, illegal, accept, cnt_wr;
    logic [XLEN-1:0] cnt [32];
    logic [XLEN-1:0] old_val, new_val;

    logic            rsp_valid_q, rsp_illegal_q;
    logic [XLEN-1:0] rsp_rdata_q;

    assign idx         = req_addr_i[4:0];
    assign req_ready_o = !rsp_valid_q || rsp_ready_i;
    assign accept      = req_valid_i && req_ready_o;
    assign old_val     = cnt[idx];

    always_comb begin
        in_m    = (req_addr_i[11:5] == CSR_MCNT_PAGE);
        in_u    = (req_addr_i[11:5] == CSR_UCNT_PAGE);
        illegal = 1'b0;
        if (!in_m && !in_u) begin
            illegal = 1'b1;
        end else if (idx == 5'd1) begin
            // Offset 1 (time) has no backing counter in either window.
            illegal = 1'b1;
        end else if (in_m && req_priv_i != PRIV_M) begin
            illegal = 1'b1;
        end else if (in_u && req_wr_i) begin
            illegal = 1'b1;
        end else if (in_u && req_priv_i != PRIV_M && !mcounteren_i[idx]) begin
            illegal = 1'b1;
        end
    end

    always_comb begin
        cnt_wr = accept && !illegal && in_m && req_wr_i && (req_op_i != CSR_OP_NONE)
                 && (idx < 5'(HPM_RESERVED_FIRST));
        unique case (req_op_i)
            CSR_OP_RW: new_val = req_wdata_i;
            CSR_OP_RS: new_val = old_val | req_wdata_i;
            CSR_OP_RC: new_val = old_val & ~req_wdata_i;
            default:   new_val = old_val;
        endcase
    end

    for (genvar i = 0; i < 32; i++) begin : g_cnt
        if (i == 1 || i >= int'(HPM_RESERVED_FIRST)) begin : g_none
            assign cnt[i] = '0;
        end else begin : g_impl
            logic inc;
            if (i == 0) begin : g_cycle
                assign inc = 1'b1;
            end else if (i == 2) begin : g_instret
                assign inc = instret_inc_i;
            end else begin : g_evt
                assign inc = evt_i[i-3];
            end
            hpm_counter #(
                .Width(XLEN)
            ) u_cnt (
                .clk_i   (clk_i),
                .reset_ni(reset_ni),
                .wr_en_i (cnt_wr && (idx == 5'(i))),
                .wdata_i (new_val),
                .inc_i   (inc),
                .value_o (cnt[i])
            );
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_illegal_q <= 1'b0;
        end else if (accept) begin
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= illegal ? '0 : old_val;
            rsp_illegal_q <= illegal;
        end else if (rsp_ready_i) begin
            rsp_valid_q   <= 1'b0;
        end
    end

    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_rdata_o   = rsp_rdata_q;
    assign rsp_illegal_o = rsp_illegal_q;

endmodule

// File: tb/tb_csr_hpm_counters.sv
// Directed bench for csr_hpm_counters with hand-computed expected values.
module tb_csr_hpm_counters;
    import riscv::*;

    localparam logic [1:0] PRIV_U = 2'b00;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid, req_ready, req_wr;
    csr_reg_t    req_addr;
    csr_op_t     req_op;
    logic [63:0] req_wdata;
    logic [1:0]  req_priv;
    logic [31:0] mcounteren;
    logic        instret_inc;
    logic [13:0] evt;
    logic        rsp_valid, rsp_ready, rsp_illegal;
    logic [63:0] rsp_rdata;

    logic [63:0] cyc;
    int          n_checks = 0;
    int          n_pass   = 0;

    csr_hpm_counters dut (
        .clk_i        (clk),
        .reset_ni     (reset_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_addr_i   (req_addr),
        .req_op_i     (req_op),
        .req_wr_i     (req_wr),
        .req_wdata_i  (req_wdata),
        .req_priv_i   (req_priv),
        .mcounteren_i (mcounteren),
        .instret_inc_i(instret_inc),
        .evt_i        (evt),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_rdata_o  (rsp_rdata),
        .rsp_illegal_o(rsp_illegal)
    );

    always #5 clk = ~clk;

    // Reference mcycle: posedges seen since reset release.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= '0;
        else          cyc <= cyc + 64'd1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else             n_pass++;
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic do_req(input csr_reg_t addr, input csr_op_t op, input logic wr,
                          input logic [63:0] wdata, input logic [1:0] priv, input logic evt0,
                          output logic [63:0] rdata, output logic ill);
        req_valid = 1'b1;
        req_addr  = addr;
        req_op    = op;
        req_wr    = wr;
        req_wdata = wdata;
        req_priv  = priv;
        evt[0]    = evt0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_wr    = 1'b0;
        evt[0]    = 1'b0;
        @(negedge clk);
        rdata = rsp_rdata;
        ill   = rsp_illegal;
    endtask

    task automatic pulse_evt(input int b, input int n);
        for (int k = 0; k < n; k++) begin
            evt[b] = 1'b1;
            @(negedge clk);
            evt[b] = 1'b0;
        end
    endtask

    logic [63:0] rd, exp_v;
    logic        il;

    initial begin
        reset_n     = 1'b0;
        req_valid   = 1'b0;
        req_addr    = '0;
        req_op      = CSR_OP_NONE;
        req_wr      = 1'b0;
        req_wdata   = '0;
        req_priv    = PRIV_M;
        mcounteren  = '0;
        instret_inc = 1'b0;
        evt         = '0;
        rsp_ready   = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("rst_rsp_rdata", rsp_rdata, 64'd0);
        check("rst_rsp_illegal", {63'd0, rsp_illegal}, 64'd0);
        check("rst_req_ready", {63'd0, req_ready}, 64'd1);
        reset_n = 1'b1;

        // mcycle after 10 idle cycles
        repeat (10) @(posedge clk);
        @(negedge clk);
        do_req(12'hB00, CSR_OP_RW, 1'b0, 64'd0, PRIV_M, 1'b0, rd, il);
        check("mcycle_10", rd, 64'd10);
        check("mcycle_10_ill", {63'd0, il}, 64'd0);

        // minstret write all-ones then wrap
        do_req(12'hB02, CSR_OP_RW, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, PRIV_M, 1'b0, rd, il);
        check("minstret_old", rd, 64'd0);
        check("minstret_wr_ill", {63'd0, il}, 64'd0);
        instret_inc = 1'b1;
        @(negedge clk);
        instret_inc = 1'b0;
        do_req(12'hC02, CSR_OP_RS, 1'b0, 64'd0, PRIV_M, 1'b0, rd, il);
        check("minstret_wrap", rd, 64'd0);
        check("minstret_wrap_ill", {63'd0, il}, 64'd0);

        // U-mode shadow access gated by mcounteren
        pulse_evt(2, 3);
        do_req(12'hC05, CSR_OP_RS, 1'b0, 64'd0, PRIV_U, 1'b0, rd, il);
        check("u_c05_gated_ill", {63'd0, il}, 64'd1);
        check("u_c05_gated_rd", rd, 64'd0);
        mcounteren = 32'h0000_0020;
        do_req(12'hC05, CSR_OP_RS, 1'b0, 64'd0, PRIV_U, 1'b0, rd, il);
        check("u_c05_en_ill", {63'd0, il}, 64'd0);
        check("u_c05_en_rd", rd, 64'd3);
        do_req(12'hB05, CSR_OP_RS, 1'b0, 64'd0, PRIV_U, 1'b0, rd, il);
        check("u_b05_ill", {63'd0, il}, 64'd1);
        check("u_b05_rd", rd, 64'd0);

        // write beats increment in the same cycle
        pulse_evt(0, 5);
        do_req(12'hB03, CSR_OP_RS, 1'b1, 64'hF0, PRIV_M, 1'b1, rd, il);
        check("rs_b03_old", rd, 64'd5);
        do_req(12'hB03, CSR_OP_RS, 1'b0, 64'd0, PRIV_M, 1'b0, rd, il);
        check("rs_b03_new", rd, 64'hF5);
        do_req(12'hB03, CSR_OP_RC, 1'b1, 64'h0F, PRIV_M, 1'b0, rd, il);
        check("rc_b03_old", rd, 64'hF5);
        do_req(12'hB03, CSR_OP_RS, 1'b0, 64'd0, PRIV_M, 1'b0, rd, il);
        check("rc_b03_new", rd, 64'hF0);

        // reserved, shadow write, unimplemented and out-of-range addresses
        do_req(12'hB11, CSR_OP_RS, 1'b0, 64'd0, PRIV_M, 1'b0, rd, il);
        check("b11_rd", rd, 64'd0);
        check("b11_ill", {63'd0, il}, 64'd0);
        do_req(12'hB11, CSR_OP_RW, 1'b1, 64'h1234, PRIV_M, 1'b0, rd, il);
        do_req(12'hB11, CSR_OP_RS, 1'b0, 64'd0, PRIV_M, 1'b0, rd, il);
        check("b11_ignores_wr", rd, 64'd0);
        do_req(12'hC00, CSR_OP_RW, 1'b1, 64'd0, PRIV_M, 1'b0, rd, il);
        check("c00_wr_ill", {63'd0, il}, 64'd1);
        check("c00_wr_rd", rd, 64'd0);
        exp_v = cyc;
        do_req(12'hB00, CSR_OP_RS, 1'b0, 64'd0, PRIV_M, 1'b0, rd, il);
        check("mcycle_intact", rd, exp_v);
        do_req(12'hB01, CSR_OP_RS, 1'b0, 64'd0, PRIV_M, 1'b0, rd, il);
        check("b01_ill", {63'd0, il}, 64'd1);
        do_req(12'h300, CSR_OP_RS, 1'b0, 64'd0, PRIV_M, 1'b0, rd, il);
        check("300_ill", {63'd0, il}, 64'd1);

        // response backpressure
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 12'hC05;
        req_op    = CSR_OP_RS;
        req_wr    = 1'b0;
        req_priv  = PRIV_M;
        @(posedge clk);
        #1;
        req_addr = 12'hB03;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_req_ready", {63'd0, req_ready}, 64'd0);
            check("stall_rsp_valid", {63'd0, rsp_valid}, 64'd1);
            check("stall_rsp_rdata", rsp_rdata, 64'd3);
        end
        rsp_ready = 1'b1;
        #1;
        check("release_req_ready", {63'd0, req_ready}, 64'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("b2b_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        check("b2b_rsp_rdata", rsp_rdata, 64'hF0);

        // asynchronous reset mid-transaction
        req_valid = 1'b1;
        req_addr  = 12'hB03;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_valid", {63'd0, rsp_valid}, 64'd0);
        check("async_rst_rdata", rsp_rdata, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        do_req(12'hB03, CSR_OP_RS, 1'b0, 64'd0, PRIV_M, 1'b0, rd, il);
        check("async_rst_cleared", rd, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
